// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Round-robin arbiter sharing one single-port synchronous SRAM
//                between two requesters (A, B). One access in flight at a
//                time, with read data returned to the granted requester.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   // requester A
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   // requester B
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   // SRAM side
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   // WAIT lasts READ_LAT cycles: counter loads READ_LAT-1 and ends at zero
   localparam int                 C_CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(READ_LAT - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_accept;
   logic                w_win_b;
   logic                w_rd_done;

   logic                r_prio_b;   // 1: B wins the next tie
   logic                r_id;       // 0: A owns the access, 1: B
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [C_CNT_W-1:0]  r_cnt;
   logic                r_a_rvalid;
   logic                r_b_rvalid;
   logic [DATA_W-1:0]   r_a_rdata;
   logic [DATA_W-1:0]   r_b_rdata;

   // Next-state and arbitration decision
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_win_b     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (a_req || b_req) begin
               w_accept    = 1'b1;
               w_win_b     = b_req && (!a_req || r_prio_b);
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: w_state_nxt = r_we ? S_IDLE : S_WAIT;
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_rd_done = (r_state == S_WAIT) && (r_cnt == '0);

   // State register; reset aborts any in-flight access
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Winner's request latch, round-robin pointer and latency counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prio_b <= 1'b0;
         r_id     <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_accept) begin
            r_id     <= w_win_b;
            r_prio_b <= !w_win_b;
            r_we     <= w_win_b ? b_we    : a_we;
            r_addr   <= w_win_b ? b_addr  : a_addr;
            r_wdata  <= w_win_b ? b_wdata : a_wdata;
         end
         if (r_state == S_ISSUE) begin
            r_cnt <= C_CNT_LOAD;
         end else if (r_state == S_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - C_CNT_W'(1);
         end
      end
   end

   // Read return: capture on the last WAIT cycle, pulse rvalid the cycle after
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
         r_a_rdata  <= '0;
         r_b_rdata  <= '0;
      end else begin
         r_a_rvalid <= w_rd_done && !r_id;
         r_b_rvalid <= w_rd_done &&  r_id;
         if (w_rd_done && !r_id) begin
            r_a_rdata <= mem_rdata;
         end
         if (w_rd_done && r_id) begin
            r_b_rdata <= mem_rdata;
         end
      end
   end

   // Strobes decode straight from state so reset drops them immediately
   assign a_gnt     = (r_state == S_ISSUE) && !r_id;
   assign b_gnt     = (r_state == S_ISSUE) &&  r_id;
   assign mem_en    = (r_state == S_ISSUE);
   assign mem_we    = (r_state == S_ISSUE) && r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign a_rvalid  = r_a_rvalid;
   assign b_rvalid  = r_b_rvalid;
   assign a_rdata   = r_a_rdata;
   assign b_rdata   = r_b_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_arbiter
//  Description : Directed self-checking bench for sram_arbiter with a
//                behavioural SRAM of READ_LAT cycles latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_arbiter;

   localparam int C_RL = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [7:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
   logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [7:0] a_rdata, b_rdata;
   logic       mem_en, mem_we;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;

   int n_checks = 0;
   int n_errors = 0;
   int n_en = 0, n_agnt = 0, n_brv = 0, n_both = 0;

   sram_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LAT(C_RL)) u_dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: samples every edge, data emerges C_RL cycles later
   logic [7:0] r_mem [256];
   logic [7:0] r_pipe [C_RL];
   initial begin
      for (int i = 0; i < 256; i++) r_mem[i] = 8'h00;
      for (int i = 0; i < C_RL; i++) r_pipe[i] = 8'h00;
   end
   always @(posedge clk) begin
      if (mem_en && mem_we) r_mem[mem_addr] <= mem_wdata;
      r_pipe[0] <= r_mem[mem_addr];
      for (int i = 1; i < C_RL; i++) r_pipe[i] <= r_pipe[i-1];
   end
   assign mem_rdata = r_pipe[C_RL-1];

   // Event counters sampled mid-cycle
   always @(negedge clk) begin
      if (mem_en)          n_en++;
      if (a_gnt)           n_agnt++;
      if (b_rvalid)        n_brv++;
      if (a_gnt && b_gnt)  n_both++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request, expect its grant one cycle later, then withdraw
   task automatic req_op(input string tag, input bit pb, input bit we,
                         input logic [7:0] addr, input logic [7:0] wd);
      if (pb) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
      else    begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
      tick();
      check({tag, "_gnt"}, {a_gnt, b_gnt}, pb ? 2'b01 : 2'b10);
      check({tag, "_mem"}, {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, we, addr, wd});
      a_req = 0;
      b_req = 0;
   endtask

   // Count cycles from the grant cycle to the rvalid pulse of the given port
   task automatic wait_rv(input string tag, input bit pb);
      int n = 0;
      while (!(pb ? b_rvalid : a_rvalid) && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, n, C_RL + 1);
   endtask

   // Tie of two writes; returns which port won
   task automatic tie(output bit wasb);
      a_req = 1; a_we = 1; a_addr = 8'h40; a_wdata = 8'h44;
      b_req = 1; b_we = 1; b_addr = 8'h50; b_wdata = 8'h55;
      tick();
      wasb = b_gnt;
      check("tie_one_gnt", {a_gnt, b_gnt} == 2'b01 || {a_gnt, b_gnt} == 2'b10, 1'b1);
      a_req = 0;
      b_req = 0;
      tick();
   endtask

   initial begin
      bit         wb;
      logic [3:0] seq;
      int         ng, cyc, last_g, en0, ag0, brv0;

      // Reset state
      tick(); tick();
      check("reset_outs", {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_we,
                           mem_addr, mem_wdata, a_rdata, b_rdata}, '0);
      reset = 0;
      tick();

      // 1: A write 0x05 <- 0xA5, B stays quiet
      req_op("t1", 0, 1, 8'h05, 8'hA5);
      tick();
      check("t1_idle_en", {mem_en, a_gnt, b_gnt}, 3'b000);

      // 2: A read 0x05
      req_op("t2", 0, 0, 8'h05, 8'h00);
      wait_rv("t2", 0);
      check("t2_rdata", {a_rdata, b_rdata}, {8'hA5, 8'h00});
      tick();
      check("t2_rv_pulse", a_rvalid, 1'b0);

      // B write so the next tie belongs to A
      req_op("pre3", 1, 1, 8'h30, 8'h33);
      tick();

      // 3: held tie, four writes, order A,B,A,B at one grant per two cycles
      a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 8'h11;
      b_req = 1; b_we = 1; b_addr = 8'h20; b_wdata = 8'h22;
      ng = 0; cyc = 0; seq = '0; last_g = 0;
      while (ng < 4 && cyc < 20) begin
         tick();
         cyc++;
         if (a_gnt || b_gnt) begin
            seq = {seq[2:0], b_gnt};
            ng++;
            last_g = cyc;
         end
      end
      a_req = 0;
      b_req = 0;
      check("t3_order", seq, 4'b0101);
      check("t3_4th_gnt_cycle", last_g, 7);
      check("t3_both_gnt", n_both, 0);
      tick();

      // 4: address/data extremes
      req_op("t4w", 1, 1, 8'hFF, 8'hFF);
      tick();
      req_op("t4r", 0, 0, 8'hFF, 8'h00);
      wait_rv("t4", 0);
      check("t4_rdata", {a_rdata, b_rdata}, {8'hFF, 8'h00});
      tick();

      // 6: A pulses req during B's WAIT -> ignored
      en0 = n_en; ag0 = n_agnt;
      req_op("t6", 1, 0, 8'h05, 8'h00);
      tick();
      a_req = 1; a_we = 1; a_addr = 8'h77; a_wdata = 8'h77;
      tick();
      a_req = 0;
      tick();
      check("t6_brv", b_rvalid, 1'b1);
      check("t6_rdata", {a_rdata, b_rdata}, {8'hFF, 8'hA5});
      repeat (3) tick();
      check("t6_no_agnt", n_agnt - ag0, 0);
      check("t6_one_en", n_en - en0, 1);

      // 5: reset in WAIT of a B read
      brv0 = n_brv;
      req_op("t5", 1, 0, 8'h30, 8'h00);
      tick();
      reset = 1;
      #1;
      check("t5_async_outs", {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_we,
                              mem_addr, mem_wdata, a_rdata, b_rdata}, '0);
      tick(); tick();
      reset = 0;
      repeat (4) tick();
      check("t5_no_brv", n_brv - brv0, 0);
      tie(wb);
      check("t5_tie_a", wb, 1'b0);
      tie(wb);
      check("t5_tie_b", wb, 1'b1);

      // Pointer returns to A even right after an A grant
      req_op("t5b", 0, 1, 8'h01, 8'h01);
      reset = 1;
      #1;
      check("t5b_we_drop", {mem_en, mem_we, a_gnt}, 3'b000);
      tick();
      reset = 0;
      tick();
      tie(wb);
      check("t5b_tie_a", wb, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute time bound
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
`default_nettype wire
